// File: rtl/register_file.sv
// Two-read / one-write register file with write-first bypass on both read ports.
// Register 0 is hardwired to zero, and reset clears all storage asynchronously.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EnableWrite,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  write_hit;

    // A write aimed at register 0 is treated as no write at all, which also
    // keeps the bypass path from ever forwarding into index 0.
    assign write_hit = EnableWrite && (write_reg != '0);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (write_hit && (write_reg == ADDR_WIDTH'(i))) begin
                regs_d[i] = write_data;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Outputs are forced to zero during reset so that the bypass cannot leak
    // write_data out while the storage is held clear.
    always_comb begin
        data_out1 = '0;
        data_out2 = '0;
        if (rst_n) begin
            if (read_reg1 != '0) begin
                data_out1 = (write_hit && (write_reg == read_reg1)) ? write_data : regs_q[read_reg1];
            end
            if (read_reg2 != '0) begin
                data_out2 = (write_hit && (write_reg == read_reg2)) ? write_data : regs_q[read_reg2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, writes, bypass,
// register-0 behaviour and asynchronous reset cancelling pending writes.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          EnableWrite;
    logic [AW-1:0] read_reg1;
    logic [AW-1:0] read_reg2;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [DW-1:0] data_out1;
    logic [DW-1:0] data_out2;

    int checks_cnt;
    int fail_cnt;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .EnableWrite(EnableWrite),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .data_out1  (data_out1),
        .data_out2  (data_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s val=0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        EnableWrite = 1'b1;
        write_reg   = addr;
        write_data  = data;
        tick();
        EnableWrite = 1'b0;
    endtask

    initial begin
        checks_cnt  = 0;
        fail_cnt    = 0;
        rst_n       = 1'b0;
        EnableWrite = 1'b0;
        read_reg1   = 5'd8;
        read_reg2   = 5'd31;
        write_reg   = '0;
        write_data  = '0;
        #12;
        check_val("reset_out1", data_out1, 32'h0);
        check_val("reset_out2", data_out2, 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic write then read back on both ports
        wr(5'd8, 32'd90);
        read_reg1 = 5'd8;
        read_reg2 = 5'd0;
        #1;
        check_val("wr8_out1", data_out1, 32'd90);
        check_val("wr8_out2_r0", data_out2, 32'd0);

        // Disabled write must not land
        EnableWrite = 1'b0;
        write_reg   = 5'd8;
        write_data  = 32'd45;
        tick();
        check_val("we0_suppressed", data_out1, 32'd90);

        // Register 0 discards writes and never bypasses
        EnableWrite = 1'b1;
        write_reg   = 5'd0;
        write_data  = 32'hFFFF_FFFF;
        read_reg1   = 5'd0;
        read_reg2   = 5'd0;
        #1;
        check_val("r0_nobypass", data_out1, 32'h0);
        tick();
        EnableWrite = 1'b0;
        check_val("r0_out1", data_out1, 32'h0);
        check_val("r0_out2", data_out2, 32'h0);

        // Dual-port bypass in the same cycle, then stored value after the edge
        EnableWrite = 1'b1;
        write_reg   = 5'd5;
        write_data  = 32'h0000_1234;
        read_reg1   = 5'd5;
        read_reg2   = 5'd5;
        #1;
        check_val("bypass_out1", data_out1, 32'h0000_1234);
        check_val("bypass_out2", data_out2, 32'h0000_1234);
        tick();
        EnableWrite = 1'b0;
        #1;
        check_val("stored5_out1", data_out1, 32'h0000_1234);
        check_val("stored5_out2", data_out2, 32'h0000_1234);

        // Bypass on one port only
        EnableWrite = 1'b1;
        write_reg   = 5'd6;
        write_data  = 32'h0000_0066;
        read_reg1   = 5'd5;
        read_reg2   = 5'd6;
        #1;
        check_val("bypass_p1_nohit", data_out1, 32'h0000_1234);
        check_val("bypass_p2_hit", data_out2, 32'h0000_0066);
        tick();
        EnableWrite = 1'b0;

        // Top and bottom registers with alternating patterns
        wr(5'd31, 32'hAAAA_AAAA);
        wr(5'd1, 32'h5555_5555);
        read_reg1 = 5'd31;
        read_reg2 = 5'd1;
        #1;
        check_val("r31_pattern", data_out1, 32'hAAAA_AAAA);
        check_val("r1_pattern", data_out2, 32'h5555_5555);

        // Distinct values in every register, read back through both ports
        for (int i = 1; i < 32; i++) begin
            wr(AW'(i), 32'hC0DE_0000 + 32'(i * 17));
        end
        for (int i = 1; i < 32; i++) begin
            read_reg1 = AW'(i);
            read_reg2 = AW'(32 - i);
            #1;
            check_val($sformatf("fill_p1_r%0d", i), data_out1, 32'hC0DE_0000 + 32'(i * 17));
            check_val($sformatf("fill_p2_r%0d", 32 - i), data_out2, 32'hC0DE_0000 + 32'((32 - i) * 17));
        end

        // Asynchronous reset mid-cycle, no clock edge in between
        @(posedge clk);
        #3;
        read_reg1 = 5'd31;
        read_reg2 = 5'd1;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_out1", data_out1, 32'h0);
        check_val("async_rst_out2", data_out2, 32'h0);

        // No bypass and no write while reset is held
        EnableWrite = 1'b1;
        write_reg   = 5'd3;
        write_data  = 32'hDEAD_BEEF;
        read_reg1   = 5'd3;
        #1;
        check_val("rst_nobypass", data_out1, 32'h0);
        tick();
        EnableWrite = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check_val("rst_write_blocked", data_out1, 32'h0);

        // Reset arriving between write setup and the edge cancels the write
        @(posedge clk);
        #1;
        EnableWrite = 1'b1;
        write_reg   = 5'd7;
        write_data  = 32'h0000_0077;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        EnableWrite = 1'b0;
        #2;
        rst_n = 1'b1;
        read_reg1 = 5'd7;
        #1;
        check_val("rst_cancel_r7", data_out1, 32'h0);

        for (int i = 0; i < 32; i++) begin
            read_reg1 = AW'(i);
            read_reg2 = AW'(31 - i);
            #1;
            check_val($sformatf("post_rst_p1_r%0d", i), data_out1, 32'h0);
            check_val($sformatf("post_rst_p2_r%0d", 31 - i), data_out2, 32'h0);
        end

        // First write after reset release lands at the next edge
        wr(5'd9, 32'h0000_0099);
        read_reg1 = 5'd9;
        #1;
        check_val("first_write_after_rst", data_out1, 32'h0000_0099);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
